// File: rtl/data_mem_be_pkg.sv
// data_mem_be_pkg: shared constants for the byte-enabled data memory
package data_mem_be_pkg;
  localparam int BYTE_W = 8;
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  function automatic int num_be(input int dw);
    return dw / BYTE_W;
  endfunction
endpackage

// File: rtl/data_mem_be_if.sv
// data_mem_be_if: request/response bus between the memory stage and data_mem_be
interface data_mem_be_if
  import data_mem_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int NUM_BE = num_be(DATA_WIDTH);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_BE-1:0]     req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  clear;
  logic                  busy;
  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, clear,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, clear,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_be_array.sv
// data_mem_be_array: single-port byte-enabled RAM with registered read-before-write data
module data_mem_be_array
  import data_mem_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [num_be(DATA_WIDTH)-1:0]  be_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);
  localparam int NUM_BE = num_be(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem[addr_i];
      for (int i = 0; i < NUM_BE; i++)
        if (we_i && be_i[i]) mem[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_be.sv
// data_mem_be: data memory with valid/ready requests, registered responses and a zero-fill engine
module data_mem_be
  import data_mem_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  data_mem_be_if.slave bus_io
);
  localparam int NUM_BE = num_be(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_C = DEPTH_C - 1'b1;
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_err_q, rd_q;
  logic                  fill, acc, in_range;
  logic                  arr_en, arr_we;
  logic [NUM_BE-1:0]     arr_be;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  always_comb begin
    fill      = state_q == ST_FILL;
    acc       = bus_io.req_valid && !fill;
    in_range  = {1'b0, bus_io.req_addr} < DEPTH_C;
    arr_en    = fill || (acc && in_range);
    arr_we    = fill || (acc && in_range && bus_io.req_we);
    arr_addr  = fill ? cnt_q[ADDR_WIDTH-1:0] : bus_io.req_addr;
    arr_be    = fill ? '1 : bus_io.req_be;
    arr_wdata = fill ? '0 : bus_io.req_wdata;
    state_d   = fill ? (cnt_q == LAST_C ? ST_RUN : ST_FILL) : (bus_io.clear ? ST_FILL : ST_RUN);
    cnt_d     = fill ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= acc;
      rsp_err_q   <= acc && !in_range;
      rd_q        <= acc && in_range && !bus_io.req_we;
    end
  end
  data_mem_be_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_array (
    .clk    (clk),
    .en_i   (arr_en),
    .we_i   (arr_we),
    .be_i   (arr_be),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );
  // Array output holds stale data between reads, so gate it to zero unless a read response is due.
  assign bus_io.req_ready = !fill;
  assign bus_io.busy      = fill;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_err   = rsp_err_q;
  assign bus_io.rsp_rdata = rd_q ? arr_rdata : '0;
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed plus random checks of data_mem_be against a word-array reference model
module tb_data_mem_be;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 20;
  logic clk, rst;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [DW-1:0] mem_m [DEPTH];

  data_mem_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  data_mem_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 1);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n, DEPTH);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
  endtask

  // One accepted request; the response is checked right after the accepting edge.
  task automatic req(input bit we, input logic [3:0] be, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit clr);
    logic [DW-1:0] exp_d;
    bit err;
    err = int'(addr) >= DEPTH;
    exp_d = '0;
    if (!err && !we) exp_d = mem_m[addr];
    if (!err && we)
      for (int i = 0; i < 4; i++) if (be[i]) mem_m[addr][8*i +: 8] = wd[8*i +: 8];
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_be = be;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.clear = clr;
    tick();
    bus.req_valid = 1'b0;
    bus.clear = 1'b0;
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 1);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, err});
    chk("rsp_rdata", bus.rsp_rdata, exp_d);
    if (clr) begin
      zero_model();
      chk("busy_after_clear", {31'd0, bus.busy}, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_be = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.clear = 1'b0;
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    wait_ready("reset_fill_len");
    zero_model();
    for (int a = 0; a < DEPTH; a++) req(1'b0, 4'h0, AW'(a), '0, 1'b0);
    tick();
    chk("idle_no_rsp", {31'd0, bus.rsp_valid}, 0);

    req(1'b1, 4'b1111, 5'd3, 32'hAABBCCDD, 1'b0);
    req(1'b1, 4'b0101, 5'd3, 32'h11223344, 1'b0);
    req(1'b0, 4'b0000, 5'd3, 32'h0, 1'b0);
    chk("be_merge", bus.rsp_rdata, 32'hAA22CC44);
    req(1'b1, 4'b0000, 5'd3, 32'hFFFFFFFF, 1'b0);
    req(1'b0, 4'b1111, 5'd3, 32'h0, 1'b0);

    for (int a = 0; a < 8; a++) req(1'b1, 4'hF, AW'(a), 32'(a) * 32'h01010101, 1'b0);
    for (int a = 0; a < 8; a++) req(1'b0, 4'h0, AW'(a), '0, 1'b0);
    req(1'b1, 4'hF, 5'd9, 32'h13579BDF, 1'b0);
    req(1'b0, 4'h0, 5'd9, '0, 1'b0);

    req(1'b1, 4'hF, 5'd5, 32'h55AA55AA, 1'b0);
    req(1'b1, 4'hF, 5'd25, 32'hDEADBEEF, 1'b0);
    req(1'b0, 4'h0, 5'd25, '0, 1'b0);
    req(1'b0, 4'h0, 5'd5, '0, 1'b0);
    chk("oor_no_alias", bus.rsp_rdata, 32'h55AA55AA);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) != 0)
        req(1'($urandom), 4'($urandom), AW'($urandom), $urandom, 1'b0);
      else begin
        tick();
        chk("rand_idle", {31'd0, bus.rsp_valid}, 0);
      end
    end

    req(1'b1, 4'hF, 5'd7, 32'h0BADCAFE, 1'b0);
    req(1'b1, 4'hF, 5'd2, 32'h5, 1'b1);
    wait_ready("clear_fill_len");
    req(1'b0, 4'h0, 5'd2, '0, 1'b0);
    req(1'b0, 4'h0, 5'd7, '0, 1'b0);

    req(1'b1, 4'hF, 5'd1, 32'hCAFEF00D, 1'b0);
    req(1'b0, 4'h0, 5'd1, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midfill_rst");
    tick();
    rst = 1'b0;
    wait_ready("midfill_fill_len");
    zero_model();
    for (int a = 0; a < DEPTH; a++) req(1'b0, 4'h0, AW'(a), '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
